// File: rtl/nand_req_if.sv
// Request handshake between an upstream NAND engine
// and the bus-cycle sequencer.
interface nand_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_has_cmd0;
  logic [7:0]  req_cmd0;
  logic [2:0]  req_addr_cnt;
  logic [39:0] req_addr;
  logic        req_has_cmd1;
  logic [7:0]  req_cmd1;
  logic        req_wait_rb;

  modport master (
    output req_valid, req_has_cmd0, req_cmd0,
    output req_addr_cnt, req_addr,
    output req_has_cmd1, req_cmd1, req_wait_rb,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_has_cmd0, req_cmd0,
    input  req_addr_cnt, req_addr,
    input  req_has_cmd1, req_cmd1, req_wait_rb,
    output req_ready
  );
endinterface

// File: rtl/nand_cycle_sequencer.sv
// One NAND bus transaction: cmd0, 0-5 address bytes,
// cmd1, then optional tWB + ready/busy wait.
module nand_cycle_sequencer #(
  parameter int WE_LOW_CYC  = 2,
  parameter int WE_HIGH_CYC = 2,
  parameter int TWB_CYC     = 5,
  parameter int RB_TIMEOUT  = 65535
) (
  input  logic       clk,
  input  logic       reset,
  nand_req_if.slave  req,
  input  logic       rb_l,
  output logic       ce_l,
  output logic       cle,
  output logic       ale,
  output logic       we_l,
  output logic [7:0] io_out,
  output logic       io_oe,
  output logic       done,
  output logic       timeout
);

  typedef enum logic [2:0] {
    IDLE, CMD0, ADDR, CMD1, TWB, WAIT_RB, DONE
  } state_t;

  localparam logic [15:0] WE_LOW  = 16'(WE_LOW_CYC);
  localparam logic [15:0] PH_LAST =
    16'(WE_LOW_CYC + WE_HIGH_CYC - 1);
  localparam logic [15:0] TWB_LAST = 16'(TWB_CYC - 1);
  localparam logic [15:0] RB_LAST  = 16'(RB_TIMEOUT - 1);

  state_t      state_q, state_n;
  logic [15:0] cnt_q, cnt_n;
  logic [2:0]  idx_q, idx_n;
  logic        has1_q, wrb_q;
  logic [7:0]  cmd0_q, cmd1_q;
  logic [39:0] addr_q;
  logic [2:0]  acnt_q;
  logic        rb_s1, rb_s2;
  logic        ready_q;

  logic        accept, restart, to_set, ph_end;
  logic        has1_f, wrb_f;
  logic [7:0]  cmd0_f, cmd1_f;
  logic [39:0] addr_f, sh;
  logic [2:0]  acnt_in, acnt_f;
  state_t      post_s, after_addr, after_cmd0;
  logic        byte_st;
  logic [7:0]  byte_v;
  logic        to_n;

  assign req.req_ready = ready_q;

  // Fields seen this cycle: live bus on acceptance, latched copy after.
  always_comb begin
    accept  = (state_q == IDLE) && req.req_valid;
    acnt_in = (req.req_addr_cnt > 3'd5) ? 3'd5
                                        : req.req_addr_cnt;
    has1_f  = accept ? req.req_has_cmd1 : has1_q;
    wrb_f   = accept ? req.req_wait_rb  : wrb_q;
    cmd0_f  = accept ? req.req_cmd0     : cmd0_q;
    cmd1_f  = accept ? req.req_cmd1     : cmd1_q;
    addr_f  = accept ? req.req_addr     : addr_q;
    acnt_f  = accept ? acnt_in          : acnt_q;
  end

  always_comb begin
    post_s     = wrb_f ? TWB : DONE;
    after_addr = has1_f ? CMD1 : post_s;
    after_cmd0 = (acnt_f != 3'd0) ? ADDR : after_addr;
    ph_end     = (cnt_q == PH_LAST);
    state_n    = state_q;
    idx_n      = idx_q;
    restart    = 1'b0;
    to_set     = 1'b0;
    unique case (state_q)
      IDLE: begin
        idx_n = 3'd0;
        if (accept)
          state_n = req.req_has_cmd0 ? CMD0 : after_cmd0;
      end
      CMD0:
        if (ph_end) state_n = after_cmd0;
      ADDR:
        if (ph_end) begin
          if (idx_q == acnt_f - 3'd1) begin
            state_n = after_addr;
          end else begin
            idx_n   = idx_q + 3'd1;
            restart = 1'b1;
          end
        end
      CMD1:
        if (ph_end) state_n = post_s;
      TWB:
        if (cnt_q == TWB_LAST) state_n = WAIT_RB;
      WAIT_RB:
        if (rb_s2) begin
          state_n = DONE;
        end else if (cnt_q == RB_LAST) begin
          state_n = DONE;
          to_set  = 1'b1;
        end
      DONE:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
    if (state_n != state_q || restart || state_q == IDLE)
      cnt_n = 16'd0;
    else
      cnt_n = cnt_q + 16'd1;
  end

  // Pin values are derived from the next state so they register cleanly.
  always_comb begin
    byte_st = state_n inside {CMD0, ADDR, CMD1};
    sh      = addr_f >> {idx_n, 3'b000};
    byte_v  = 8'h00;
    unique case (1'b1)
      state_n == CMD0: byte_v = cmd0_f;
      state_n == ADDR: byte_v = sh[7:0];
      state_n == CMD1: byte_v = cmd1_f;
      default:         byte_v = 8'h00;
    endcase
    if (accept)      to_n = 1'b0;
    else if (to_set) to_n = 1'b1;
    else             to_n = timeout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      has1_q  <= 1'b0;
      wrb_q   <= 1'b0;
      cmd0_q  <= 8'h00;
      cmd1_q  <= 8'h00;
      addr_q  <= 40'd0;
      acnt_q  <= 3'd0;
      rb_s1   <= 1'b1;
      rb_s2   <= 1'b1;
      ready_q <= 1'b1;
      ce_l    <= 1'b1;
      cle     <= 1'b0;
      ale     <= 1'b0;
      we_l    <= 1'b1;
      io_out  <= 8'h00;
      io_oe   <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      has1_q  <= has1_f;
      wrb_q   <= wrb_f;
      cmd0_q  <= cmd0_f;
      cmd1_q  <= cmd1_f;
      addr_q  <= addr_f;
      acnt_q  <= acnt_f;
      rb_s1   <= rb_l;
      rb_s2   <= rb_s1;
      ready_q <= (state_n == IDLE);
      ce_l    <= (state_n == IDLE);
      cle     <= (state_n == CMD0) || (state_n == CMD1);
      ale     <= (state_n == ADDR);
      we_l    <= !(byte_st && (cnt_n < WE_LOW));
      io_out  <= byte_v;
      io_oe   <= byte_st;
      done    <= (state_n == DONE);
      timeout <= to_n;
    end
  end

endmodule

// File: tb/tb_nand_cycle_sequencer.sv
// Bench for nand_cycle_sequencer: directed scenarios plus
// random transactions against a cycle-list reference model.
module tb_nand_cycle_sequencer;

  localparam int WL  = 2;
  localparam int WH  = 2;
  localparam int TWB = 5;
  localparam int RBT = 10;
  localparam int BC  = WL + WH;
  localparam int STUCK = 100000;

  typedef struct packed {
    logic        has0;
    logic [7:0]  c0;
    logic [2:0]  cnt;
    logic [39:0] addr;
    logic        has1;
    logic [7:0]  c1;
    logic        wrb;
  } req_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rb_l;
  logic       ce_l, cle, ale, we_l, io_oe, done, timeout;
  logic [7:0] io_out;
  int         errors = 0;
  int         checks = 0;
  int         txn = 0;

  nand_req_if rif ();

  nand_cycle_sequencer #(
    .WE_LOW_CYC (WL),
    .WE_HIGH_CYC(WH),
    .TWB_CYC    (TWB),
    .RB_TIMEOUT (RBT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (rif.slave),
    .rb_l   (rb_l),
    .ce_l   (ce_l),
    .cle    (cle),
    .ale    (ale),
    .we_l   (we_l),
    .io_out (io_out),
    .io_oe  (io_oe),
    .done   (done),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] obs();
    return {rif.req_ready, ce_l, cle, ale, we_l,
            io_oe, done, timeout, io_out};
  endfunction

  localparam logic [15:0] RST_VEC = 16'hC800;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic put(input req_t r);
    rif.req_has_cmd0 = r.has0;
    rif.req_cmd0     = r.c0;
    rif.req_addr_cnt = r.cnt;
    rif.req_addr     = r.addr;
    rif.req_has_cmd1 = r.has1;
    rif.req_cmd1     = r.c1;
    rif.req_wait_rb  = r.wrb;
  endtask

  function automatic req_t rnd_req();
    req_t r;
    r.has0 = 1'($urandom);
    r.c0   = 8'($urandom);
    r.cnt  = 3'($urandom);
    r.addr = {8'($urandom), 32'($urandom)};
    r.has1 = 1'($urandom);
    r.c1   = 8'($urandom);
    r.wrb  = 1'($urandom);
    return r;
  endfunction

  // rise: cycle (1 = first after acceptance) in which rb_l goes high;
  // <=0 means already high, STUCK means never.
  task automatic run_txn(input req_t r, input int rise,
                         input bit chain, input req_t nxt);
    logic [7:0]  bv[8];
    bit          bc[8];
    logic [15:0] exp;
    logic [7:0]  ab;
    logic [39:0] av;
    int nb, n, w0, rdy, d, k, b, ph;
    bit tmo, is_cmd;
    txn++;
    nb = 0;
    av = r.addr;
    n  = (r.cnt > 3'd5) ? 5 : int'(r.cnt);
    if (r.has0) begin bv[nb] = r.c0; bc[nb] = 1; nb++; end
    for (int i = 0; i < n; i++) begin
      ab = av[8*i +: 8];
      bv[nb] = ab; bc[nb] = 0; nb++;
    end
    if (r.has1) begin bv[nb] = r.c1; bc[nb] = 1; nb++; end
    tmo = 0;
    if (!r.wrb) begin
      d = 1 + BC * nb;
    end else begin
      w0  = 1 + BC * nb + TWB;
      rdy = (rise <= 0) ? w0
          : ((rise + 2 > w0) ? rise + 2 : w0);
      tmo = (rdy > w0 + RBT - 1);
      d   = tmo ? w0 + RBT : rdy + 1;
    end

    put(r);
    rb_l = (rise <= 0);
    rif.req_valid = 1'b1;
    k = 0;
    while (!rif.req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("t%0d_ready", txn),
        {15'd0, rif.req_ready}, 16'd1);
    if (!rif.req_ready) return;
    @(posedge clk);
    #1;
    if (chain) begin
      put(nxt);
    end else begin
      rif.req_valid = 1'b0;
      put(rnd_req());
    end

    for (int c = 1; c <= d + 1; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (c == rise) rb_l = 1'b1;
      @(negedge clk);
      if (c <= d) begin
        if (c <= BC * nb) begin
          b  = (c - 1) / BC;
          ph = (c - 1) % BC;
          is_cmd = bc[b];
          exp = {1'b0, 1'b0, is_cmd, !is_cmd,
                 (ph >= WL), 1'b1, 1'b0, 1'b0, bv[b]};
        end else begin
          exp = {8'b00001000, 8'h00};
        end
        if (c == d) exp[9:8] = {1'b1, tmo};
      end else begin
        exp = {8'b11001000, 8'h00};
        exp[8] = tmo;
      end
      chk($sformatf("t%0d_c%0d", txn, c), obs(), exp);
    end
  endtask

  req_t r, r2, z;
  int   rise;

  initial begin
    z = '0;
    reset = 1'b1;
    rb_l  = 1'b1;
    rif.req_valid = 1'b0;
    put(z);
    #2;
    chk("reset_async", obs(), RST_VEC);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_hold", obs(), RST_VEC);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_release", obs(), RST_VEC);

    // Reset command FFh with a 20-cycle busy period
    r = '0; r.has0 = 1; r.c0 = 8'hFF; r.wrb = 1;
    run_txn(r, 21, 0, z);

    // Page read, rb_l already ready
    r = '0; r.has0 = 1; r.c0 = 8'h00; r.cnt = 3'd5;
    r.addr = 40'h0403020100; r.has1 = 1; r.c1 = 8'h30;
    r.wrb = 1;
    run_txn(r, 0, 0, z);

    // Busy never clears
    r = '0; r.has0 = 1; r.c0 = 8'h70; r.wrb = 1;
    run_txn(r, STUCK, 0, z);

    // Empty transaction also clears the sticky timeout
    r = '0;
    run_txn(r, 0, 0, z);

    // Address count 7 behaves as 5
    r = '0; r.cnt = 3'd7; r.addr = 40'hA5_5A_C3_3C_81;
    run_txn(r, 0, 0, z);

    // Back-to-back with the second request queued
    r  = '0; r.has0 = 1; r.c0 = 8'h60; r.cnt = 3'd3;
    r.addr = 40'h00_00_12_34_56; r.has1 = 1; r.c1 = 8'hD0;
    r2 = '0; r2.has0 = 1; r2.c0 = 8'h90; r2.cnt = 3'd1;
    r2.addr = 40'h00_00_00_00_20;
    run_txn(r, 0, 1, r2);
    run_txn(r2, 0, 0, z);

    // Reset in the middle of address byte 2
    r = '0; r.has0 = 1; r.cnt = 3'd5;
    r.addr = 40'h5544332211; r.wrb = 1;
    put(r);
    rif.req_valid = 1'b1;
    @(posedge clk);
    #1;
    rif.req_valid = 1'b0;
    repeat (BC + 2 * BC) @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_addr2", obs(), {8'b00010100, 8'h33});
    #1;
    reset = 1'b1;
    #1;
    chk("mid_reset_async", obs(), RST_VEC);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mid_reset_%0d", i), obs(), RST_VEC);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_reset_%0d", i), obs(), RST_VEC);
    end

    // Random transactions
    for (int i = 0; i < 24; i++) begin
      r = rnd_req();
      case ($urandom_range(0, 2))
        0:       rise = 0;
        1:       rise = int'($urandom_range(1, 45));
        default: rise = STUCK;
      endcase
      run_txn(r, rise, 0, z);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
